weight_mem_loader: RTL and testbench
====================================

Name: weight_mem_loader

Overview:
- Write-side counterpart of the per-neuron weight memories.
- Accepts a weight stream over an AXI4-Stream slave interface and writes the words in neuron-major order.
- Drives one shared write address/data bus plus a one-hot per-neuron write enable.
- Sits between the host DMA/AXI interconnect and the layer's bank of weight memories; a write-port memory can be loaded at run time instead of from an init file.

Parameters:
- numNeurons, 4, number of neuron weight memories in the layer (≥1).
- numWeight, 784, weights per neuron (≥1, ≤ 2**(addressWidth+1)).
- addressWidth, 10, memory address MSB index; the address bus is addressWidth+1 bits, matching the memory read port.
- dataWidth, 16, weight word width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  single-cycle pulse; begins a load from neuron 0, address 0.
- s_axis_tdata  input  dataWidth  weight word.
- s_axis_tvalid  input  1  word valid.
- s_axis_tlast  input  1  marks the final word of the whole load.
- s_axis_tready  output  1  loader accepts a word.
- wen  output  numNeurons  one-hot write enable; bit n selects neuron n's memory.
- waddr  output  addressWidth+1  shared write address.
- win  output  dataWidth  shared write data.
- busy  output  1  high in LOAD.
- done  output  1  one-cycle pulse when the load completes.
- err  output  1  sticky tlast-mismatch flag; cleared by rst or by an accepted start.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset values: state=IDLE, s_axis_tready=0, wen=0, waddr=0, win=0, busy=0, done=0, err=0, all counters 0.
- Handshake: a word is accepted when s_axis_tvalid && s_axis_tready at a rising edge.
- s_axis_tready is 1 only in LOAD. No internal backpressure: in LOAD every valid word is accepted.
- States:
  - IDLE: tready=0. On start, clear the address counter, neuron counter and err, then go to LOAD.
  - LOAD: busy=1, tready=1.
    - On each accepted word: register wen = one-hot(neuron counter), waddr = address counter, win = tdata.
    - Increment the address counter. At numWeight-1, wrap it to 0 and increment the neuron counter.
    - On the accepted word with neuron = numNeurons-1 and address = numWeight-1 (the final word), go to DONE.
    - Early tlast (tlast=1 on any non-final word): the word is still written, err is set, and the FSM goes to IDLE (load aborted, no done pulse).
    - Missing tlast on the final word: the word is written, err is set, and the FSM still goes to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Latency: wen/waddr/win are registered and appear one cycle after acceptance.
  - wen is low on any cycle with no acceptance in the previous cycle.
  - waddr/win hold their last values when wen is low.
- Throughput: one word per clock. The last write (wen high) occurs in the same cycle done=1.
- start while busy or in DONE: ignored, err unaffected.
- start and rst in the same cycle: rst wins.
- rst mid-load: immediate return to reset values. No further writes; memory contents already written are left as is.
- Counter widths:
  - Address counter: addressWidth+1 bits.
  - Neuron counter: clog2(numNeurons) bits, minimum 1.
  - Compare at terminal values; never rely on natural overflow.
- numNeurons=1: wen is 1 bit and always targets neuron 0.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, LOAD=2'd1, DONE=2'd2) and a clog2 constant function for counter widths.
- One sub-module: weight_addr_gen.
  - Contains the nested address/neuron counter pair.
  - Inputs: clr, inc. Outputs: addr, neuron, last_word.
  - Lets the final-word detect be tested on its own.

Test Plan (numNeurons=2, numWeight=4, addressWidth=3, dataWidth=16):
- Reset, then start and stream 8 words 0x0001..0x0008 with continuous tvalid and tlast on word 8:
  - wen=01 with waddr 0..3 / win 1..4, then wen=10 with waddr 0..3 / win 5..8.
  - One write per cycle; done pulses with the 8th write; err=0; tready falls after DONE.
- Same stream with tvalid toggled 1,0,1,0:
  - Writes occur only after accepted words, with identical address/data sequence.
  - wen low in gap cycles; done pulses once.
- tlast asserted on word 3:
  - Words 1..3 written to neuron 0 at addresses 0..2; err=1; no done; FSM back in IDLE (tready=0).
  - A following start clears err and a full 8-word load succeeds.
- 8 words with no tlast: all 8 written, done pulses, err=1.
- rst asserted after word 5 is accepted:
  - Next cycle wen=0, busy=0, tready=0.
  - A subsequent start restarts at neuron 0, address 0.
- start pulsed again during LOAD after word 2: ignored; the sequence continues to neuron 0 address 2 with the next word.

Source files
------------

// File: rtl/weight_mem_loader_pkg.sv
// Shared definitions for the weight memory loader: FSM encoding and
// counter-width helpers used by the loader and its address generator.
package weight_mem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // A single neuron still needs a 1-bit counter so the port never collapses to zero width.
    function automatic int counterWidth(input int value);
        return (clog2(value) < 1) ? 1 : clog2(value);
    endfunction

endpackage

// File: rtl/weight_mem_loader_addr_gen.sv
// Nested address/neuron counter pair for the weight loader; flags the
// final word of the whole load so it can be checked in isolation.
module weight_addr_gen
    import weight_mem_loader_pkg::*;
#(
    parameter int numNeurons   = 4,
    parameter int numWeight    = 784,
    parameter int addressWidth = 10,
    parameter int neuronWidth  = counterWidth(numNeurons)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    inc,
    output logic [addressWidth:0]   addr,
    output logic [neuronWidth-1:0]  neuron,
    output logic                    last_word
);

    typedef logic [addressWidth:0]  addr_t;
    typedef logic [neuronWidth-1:0] neuron_t;

    localparam addr_t   lastAddr   = addr_t'(numWeight - 1);
    localparam neuron_t lastNeuron = neuron_t'(numNeurons - 1);

    addr_t   r_addr;
    neuron_t r_neuron;
    logic    w_addrWrap;
    logic    w_neuronWrap;

    assign w_addrWrap   = (r_addr == lastAddr);
    assign w_neuronWrap = (r_neuron == lastNeuron);

    // Wrap on explicit terminal compares; numWeight need not be a power of two.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_addr   <= '0;
            r_neuron <= '0;
        end else if (inc) begin
            if (w_addrWrap) begin
                r_addr   <= '0;
                r_neuron <= w_neuronWrap ? '0 : r_neuron + neuron_t'(1);
            end else begin
                r_addr <= r_addr + addr_t'(1);
            end
        end
    end

    assign addr      = r_addr;
    assign neuron    = r_neuron;
    assign last_word = w_addrWrap && w_neuronWrap;

endmodule

// File: rtl/weight_mem_loader.sv
// AXI4-Stream slave that writes a weight stream into the layer's per-neuron
// memories in neuron-major order over a shared bus with one-hot enables.
module weight_mem_loader
    import weight_mem_loader_pkg::*;
#(
    parameter int numNeurons   = 4,
    parameter int numWeight    = 784,
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [dataWidth-1:0]    s_axis_tdata,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    output logic [numNeurons-1:0]   wen,
    output logic [addressWidth:0]   waddr,
    output logic [dataWidth-1:0]    win,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int neuronWidth = counterWidth(numNeurons);

    typedef logic [numNeurons-1:0] wen_t;

    state_t                   r_state;
    state_t                   w_nextState;
    logic                     w_accept;
    logic                     w_clear;
    logic [addressWidth:0]    w_addr;
    logic [neuronWidth-1:0]   w_neuron;
    logic                     w_lastWord;
    wen_t                     w_select;

    wen_t                     r_wen;
    logic [addressWidth:0]    r_waddr;
    logic [dataWidth-1:0]     r_win;
    logic                     r_err;

    assign w_accept = s_axis_tvalid && (r_state == LOAD);
    assign w_clear  = start && (r_state == IDLE);
    assign w_select = wen_t'(1) << w_neuron;

    weight_addr_gen #(
        .numNeurons   (numNeurons),
        .numWeight    (numWeight),
        .addressWidth (addressWidth),
        .neuronWidth  (neuronWidth)
    ) u_addrGen (
        .clk       (clk),
        .rst       (rst),
        .clr       (w_clear),
        .inc       (w_accept),
        .addr      (w_addr),
        .neuron    (w_neuron),
        .last_word (w_lastWord)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // The final word always completes the load; an early tlast aborts it.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = LOAD;
                end
            end
            LOAD: begin
                if (w_accept) begin
                    if (w_lastWord) begin
                        w_nextState = DONE;
                    end else if (s_axis_tlast) begin
                        w_nextState = IDLE;
                    end
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Write bus is registered; address and data hold between writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wen   <= '0;
            r_waddr <= '0;
            r_win   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_wen <= w_accept ? w_select : '0;
            if (w_accept) begin
                r_waddr <= w_addr;
                r_win   <= s_axis_tdata;
            end
            if (w_clear) begin
                r_err <= 1'b0;
            end else if (w_accept && (s_axis_tlast != w_lastWord)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign s_axis_tready = (r_state == LOAD);
    assign busy          = (r_state == LOAD);
    assign done          = (r_state == DONE);
    assign wen           = r_wen;
    assign waddr         = r_waddr;
    assign win           = r_win;
    assign err           = r_err;

endmodule

// File: tb/tb_weight_mem_loader.sv
// Directed self-checking bench for weight_mem_loader with a 2-neuron,
// 4-weight configuration; expected write sequences are computed by hand.
module tb_weight_mem_loader;

    localparam int N  = 2;
    localparam int W  = 4;
    localparam int AW = 3;
    localparam int DW = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [DW-1:0]  s_axis_tdata;
    logic           s_axis_tvalid;
    logic           s_axis_tlast;
    logic           s_axis_tready;
    logic [N-1:0]   wen;
    logic [AW:0]    waddr;
    logic [DW-1:0]  win;
    logic           busy;
    logic           done;
    logic           err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    weight_mem_loader #(
        .numNeurons   (N),
        .numWeight    (W),
        .addressWidth (AW),
        .dataWidth    (DW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .wen           (wen),
        .waddr         (waddr),
        .win           (win),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [DW-1:0] data, input logic last);
        s_axis_tvalid = valid;
        s_axis_tdata  = data;
        s_axis_tlast  = last;
        tick();
    endtask

    task automatic startPulse();
        start         = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        tick();
        start = 1'b0;
    endtask

    // Word idx (0-based) carries data idx+1 and lands at neuron idx/W, address idx%W.
    task automatic sendWord(input int idx, input logic last, input logic expDone, input logic expErr);
        applyStimulus(1'b1, DW'(idx + 1), last);
        checkOutput($sformatf("wen[w%0d]", idx + 1), 32'(wen), 32'(1 << (idx / W)));
        checkOutput($sformatf("waddr[w%0d]", idx + 1), 32'(waddr), 32'(idx % W));
        checkOutput($sformatf("win[w%0d]", idx + 1), 32'(win), 32'(idx + 1));
        checkOutput($sformatf("done[w%0d]", idx + 1), 32'(done), 32'(expDone));
        checkOutput($sformatf("err[w%0d]", idx + 1), 32'(err), 32'(expErr));
    endtask

    task automatic gapCycle(input int idx);
        applyStimulus(1'b0, 16'hFFFF, 1'b0);
        checkOutput($sformatf("gapWen[w%0d]", idx + 1), 32'(wen), 32'd0);
        checkOutput($sformatf("gapWaddr[w%0d]", idx + 1), 32'(waddr), 32'(idx % W));
        checkOutput($sformatf("gapWin[w%0d]", idx + 1), 32'(win), 32'(idx + 1));
        checkOutput($sformatf("gapDone[w%0d]", idx + 1), 32'(done), 32'd0);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "Tready"}, 32'(s_axis_tready), 32'd0);
        checkOutput({tag, "Busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "Done"}, 32'(done), 32'd0);
        checkOutput({tag, "Wen"}, 32'(wen), 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;

        tick();
        tick();
        checkOutput("rstTready", 32'(s_axis_tready), 32'd0);
        checkOutput("rstWen", 32'(wen), 32'd0);
        checkOutput("rstWaddr", 32'(waddr), 32'd0);
        checkOutput("rstWin", 32'(win), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstDone", 32'(done), 32'd0);
        checkOutput("rstErr", 32'(err), 32'd0);
        rst = 1'b0;

        $display("[TB] continuous 8-word load");
        startPulse();
        checkOutput("t1Tready", 32'(s_axis_tready), 32'd1);
        checkOutput("t1Busy", 32'(busy), 32'd1);
        checkOutput("t1Wen", 32'(wen), 32'd0);
        for (int i = 0; i < 8; i++) begin
            sendWord(i, i == 7, i == 7, 1'b0);
        end
        applyStimulus(1'b0, '0, 1'b0);
        checkIdle("t1Post");

        $display("[TB] toggled tvalid load");
        startPulse();
        for (int i = 0; i < 8; i++) begin
            sendWord(i, i == 7, i == 7, 1'b0);
            gapCycle(i);
        end
        checkIdle("t2Post");

        $display("[TB] early tlast on word 3");
        startPulse();
        for (int i = 0; i < 3; i++) begin
            sendWord(i, i == 2, 1'b0, i == 2);
        end
        checkOutput("t3Tready", 32'(s_axis_tready), 32'd0);
        checkOutput("t3Busy", 32'(busy), 32'd0);
        gapCycle(2);
        checkOutput("t3ErrSticky", 32'(err), 32'd1);
        startPulse();
        checkOutput("t3ErrCleared", 32'(err), 32'd0);
        checkOutput("t3Busy2", 32'(busy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            sendWord(i, i == 7, i == 7, 1'b0);
        end
        applyStimulus(1'b0, '0, 1'b0);
        checkIdle("t3Post");

        $display("[TB] load with no tlast");
        startPulse();
        for (int i = 0; i < 8; i++) begin
            sendWord(i, 1'b0, i == 7, i == 7);
        end
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("t4ErrSticky", 32'(err), 32'd1);
        checkIdle("t4Post");

        $display("[TB] reset mid-load");
        startPulse();
        checkOutput("t5ErrCleared", 32'(err), 32'd0);
        for (int i = 0; i < 5; i++) begin
            sendWord(i, 1'b0, 1'b0, 1'b0);
        end
        rst = 1'b1;
        applyStimulus(1'b1, 16'h0006, 1'b0);
        rst = 1'b0;
        s_axis_tvalid = 1'b0;
        checkOutput("t5Wen", 32'(wen), 32'd0);
        checkOutput("t5Busy", 32'(busy), 32'd0);
        checkOutput("t5Tready", 32'(s_axis_tready), 32'd0);
        checkOutput("t5Waddr", 32'(waddr), 32'd0);
        checkOutput("t5Win", 32'(win), 32'd0);
        startPulse();
        for (int i = 0; i < 8; i++) begin
            sendWord(i, i == 7, i == 7, 1'b0);
        end

        $display("[TB] start during LOAD and DONE");
        applyStimulus(1'b0, '0, 1'b0);
        startPulse();
        sendWord(0, 1'b0, 1'b0, 1'b0);
        sendWord(1, 1'b0, 1'b0, 1'b0);
        startPulse();
        checkOutput("t6BusyAfterStart", 32'(busy), 32'd1);
        checkOutput("t6WenAfterStart", 32'(wen), 32'd0);
        for (int i = 2; i < 8; i++) begin
            sendWord(i, i == 7, i == 7, 1'b0);
        end
        start = 1'b1;
        applyStimulus(1'b0, '0, 1'b0);
        start = 1'b0;
        checkIdle("t6Post");
        checkOutput("t6Err", 32'(err), 32'd0);
        applyStimulus(1'b0, '0, 1'b0);
        checkIdle("t6Post2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
